serve_dispatcher: RTL
=====================

Name: serve_dispatcher

Overview:
- Consumer end of the selector interface: takes the single winning request (valid/boost/priority/zone plus source flag), holds it for a service interval, and pops the chosen source queue.
- Sits between the final selector and the shelter/food queues. It drives the serve strobes back to those queues and the dispatch outputs to the field-unit logic.
- Keeps per-source saturating served counters for status display.

Parameters:
- ZONE_W, 8, zone field width.
- PRIO_W, 2, priority field width.
- BASE_CYCLES, 4, service length for priority 0, unboosted.
- STEP_CYCLES, 2, extra service cycles per priority level.
- BOOST_CYCLES, 2, service length for any boosted request; overrides the priority formula.
- TMR_W, 8, service timer width. Must hold BASE_CYCLES+(2^PRIO_W-1)*STEP_CYCLES.
- CNT_W, 8, served-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- In_Valid  in  1  selected request present.
- In_Boost  in  1  selected request boosted.
- In_Priority  in  PRIO_W  selected request priority.
- In_Zone  in  ZONE_W  selected request zone.
- In_Select_Shelter  in  1  1=request came from shelter, 0=food.
- Unit_Ready  in  1  field unit free to take a dispatch.
- Serve_Shelter  out  1  one-cycle pop strobe to the shelter queue.
- Serve_Food  out  1  one-cycle pop strobe to the food queue.
- Dispatch_Active  out  1  a request is in service.
- Dispatch_Zone  out  ZONE_W  zone of the request in service.
- Dispatch_Shelter  out  1  source of the request in service.
- Dispatch_Done  out  1  one-cycle pulse when service completes.
- Shelter_Served  out  CNT_W  completed shelter services, saturating.
- Food_Served  out  CNT_W  completed food services, saturating.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; timer 0; counters 0.
- Reset mid-service aborts the service. No Dispatch_Done, no counter increment. An already-issued pop is not undone.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on an edge where In_Valid=1 and Unit_Ready=1. At that edge:
  - Capture zone and source.
  - Load timer with dur-1, where dur = In_Boost ? BOOST_CYCLES : BASE_CYCLES + In_Priority*STEP_CYCLES.
  - dur below 1 is clamped to 1.
- IDLE with In_Valid=0 or Unit_Ready=0: stay in IDLE, no strobes.
- Serve strobes:
  - In the first BUSY cycle, Serve_Shelter=In_Select_Shelter (captured) and Serve_Food=its inverse, high for exactly one cycle.
  - Never both high. Never high outside the first BUSY cycle.
- BUSY:
  - Dispatch_Active=1; Dispatch_Zone and Dispatch_Shelter hold the captured values.
  - Timer decrements each cycle. At timer==0, go to DONE. BUSY therefore lasts exactly dur cycles.
  - Inputs are ignored during BUSY, including In_Valid toggling and Unit_Ready dropping.
- DONE (exactly one cycle):
  - Dispatch_Done=1; Dispatch_Active=0.
  - Increment the counter for the captured source; hold at 2^CNT_W-1 once reached.
  - Dispatch_Zone keeps its value through DONE. It is cleared to 0 in IDLE.
  - Then go to IDLE. No acceptance in DONE, so the queue head has settled before the next accept.
- Throughput: at most one request per dur+2 cycles (IDLE accept, dur BUSY cycles, DONE).
- Arithmetic: compute dur at TMR_W width with no truncation. A compile-time check flags an oversize configuration.

Decomposition:
- Shared package resq_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - ZONE_W and PRIO_W defaults, also used by the selector.
  - A service-duration function.
- Sub-module sat_counter (width-parameterised, increment enable, saturating), instantiated twice for the served counters.

Test Plan:
- Reset then idle: after rst, In_Valid=0 for 10 cycles -> all outputs 0, state stays IDLE.
- Food request: Priority=2, Boost=0, Zone=8'h3C, Select_Shelter=0, Unit_Ready=1 -> Serve_Food pulse for 1 cycle; Dispatch_Active for 8 cycles with Zone 8'h3C; then Dispatch_Done pulse; Food_Served=1.
- Boosted shelter request: Priority=3, Boost=1, Zone=8'hA5 -> BUSY lasts 2 cycles, Serve_Shelter pulse, Shelter_Served=1, Serve_Food never high.
- Back-pressure: In_Valid=1 with Unit_Ready=0 for 5 cycles -> no strobe, no activity. Raise Unit_Ready -> accept on the next edge.
- Busy ignore plus reset: a new request arrives mid-BUSY and is not accepted. Assert rst on the 3rd BUSY cycle -> all outputs 0 immediately, no Dispatch_Done, counters stay 0.
- Saturation: CNT_W=2, run 5 shelter services at BOOST_CYCLES=1 -> Shelter_Served reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/resq_pkg.sv
// resq_pkg: shared FSM encoding, field-width defaults and service-duration rule
// for the rescue-queue selector and dispatcher.
package resq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_ZONE_W = 8;
    localparam int DEF_PRIO_W = 2;

    // Boost overrides the priority formula; a zero-length service is clamped to one cycle.
    function automatic int serve_dur(input logic boost, input int prio, input int base,
                                     input int step, input int bst);
        int d;
        d = boost ? bst : base + prio * step;
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/serve_dispatcher.sv
// serve_dispatcher: accepts the winning request, holds it for its service time,
// pops the source queue once and keeps saturating per-source served counts.
module serve_dispatcher
    import resq_pkg::*;
#(
    parameter int ZONE_W       = DEF_ZONE_W,
    parameter int PRIO_W       = DEF_PRIO_W,
    parameter int BASE_CYCLES  = 4,
    parameter int STEP_CYCLES  = 2,
    parameter int BOOST_CYCLES = 2,
    parameter int TMR_W        = 8,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In_Valid,
    input  logic              In_Boost,
    input  logic [PRIO_W-1:0] In_Priority,
    input  logic [ZONE_W-1:0] In_Zone,
    input  logic              In_Select_Shelter,
    input  logic              Unit_Ready,
    output logic              Serve_Shelter,
    output logic              Serve_Food,
    output logic              Dispatch_Active,
    output logic [ZONE_W-1:0] Dispatch_Zone,
    output logic              Dispatch_Shelter,
    output logic              Dispatch_Done,
    output logic [CNT_W-1:0]  Shelter_Served,
    output logic [CNT_W-1:0]  Food_Served
);
    localparam longint TMR_MAX = (64'd1 << TMR_W) - 1;
    localparam longint MAX_DUR = longint'(serve_dur(1'b0, (1 << PRIO_W) - 1, BASE_CYCLES,
                                                    STEP_CYCLES, BOOST_CYCLES));

    if (MAX_DUR > TMR_MAX || longint'(BOOST_CYCLES) > TMR_MAX) begin : g_oversize
        $error("serve_dispatcher: TMR_W too narrow for the longest service");
    end

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] dur;
    logic             finish;

    assign dur    = TMR_W'(serve_dur(In_Boost, int'(In_Priority), BASE_CYCLES, STEP_CYCLES,
                                     BOOST_CYCLES));
    assign finish = (state == BUSY) && (timer == '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state            <= IDLE;
            timer            <= '0;
            Serve_Shelter    <= 1'b0;
            Serve_Food       <= 1'b0;
            Dispatch_Active  <= 1'b0;
            Dispatch_Zone    <= '0;
            Dispatch_Shelter <= 1'b0;
            Dispatch_Done    <= 1'b0;
        end else begin
            Serve_Shelter <= 1'b0;
            Serve_Food    <= 1'b0;
            Dispatch_Done <= 1'b0;
            case (state)
                IDLE: if (In_Valid && Unit_Ready) begin
                    state            <= BUSY;
                    timer            <= dur - 1'b1;
                    Dispatch_Active  <= 1'b1;
                    Dispatch_Zone    <= In_Zone;
                    Dispatch_Shelter <= In_Select_Shelter;
                    Serve_Shelter    <= In_Select_Shelter;
                    Serve_Food       <= !In_Select_Shelter;
                end
                BUSY: if (finish) begin
                    state           <= DONE;
                    Dispatch_Active <= 1'b0;
                    Dispatch_Done   <= 1'b1;
                end else timer <= timer - 1'b1;
                DONE: begin
                    state            <= IDLE;
                    Dispatch_Zone    <= '0;
                    Dispatch_Shelter <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

    // Counts land on the BUSY->DONE edge so they are current while Dispatch_Done pulses.
    sat_counter #(.W(CNT_W)) u_shelter_cnt (
        .clk(clk), .rst(rst), .inc(finish && Dispatch_Shelter), .count(Shelter_Served)
    );
    sat_counter #(.W(CNT_W)) u_food_cnt (
        .clk(clk), .rst(rst), .inc(finish && !Dispatch_Shelter), .count(Food_Served)
    );
endmodule
